// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and one-shot access sequencer for the data memory
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wr_en_o,
  output logic        mem_rd_en_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  rerr_q, rerr_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        win;
  logic [31:0] sel_addr;
  logic [31:0] resp_data;

  // Contention goes to the port that was not served last; a lone request always wins.
  assign win      = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
  assign sel_addr = win ? m1_addr_i : m0_addr_i;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rvalid_d    = 2'b00;
    rerr_d      = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    resp_data   = 32'h0;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    case (state_q)
      IDLE: begin
        if ((m0_req_i || m1_req_i) && !reset_i) begin
          m0_gnt_o = ~win;
          m1_gnt_o = win;
          state_d  = ACCESS;
          win_d    = win;
          we_d     = win ? m1_we_i : m0_we_i;
          addr_d   = sel_addr[11:0];
          wdata_d  = win ? m1_wdata_i : m0_wdata_i;
          err_d    = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_BYTES);
        end
      end
      ACCESS: begin
        // Reset in this cycle must not let a store reach memory.
        if (!reset_i) begin
          mem_addr_o  = {20'b0, addr_q};
          mem_wdata_o = wdata_q;
          mem_rd_en_o = !we_q && !err_q;
          mem_wr_en_o = we_q && !err_q;
        end
        resp_data        = (!we_q && !err_q) ? mem_rdata_i : 32'h0;
        rvalid_d[win_q]  = 1'b1;
        rerr_d[win_q]    = err_q;
        if (win_q) rdata1_d = resp_data;
        else       rdata0_d = resp_data;
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 12'h0;
      wdata_q  <= 32'h0;
      rvalid_q <= 2'b00;
      rerr_q   <= 2'b00;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_err_o    = rerr_q[0];
  assign m1_err_o    = rerr_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } tx_t;

  typedef struct {
    int          cyc;
    int          p;
    bit          we;
    bit          rd;
    bit          e;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             init_mem;
  logic [1:0]       req, we, gnt, rvalid, err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             mem_wr_en, mem_rd_en;
  logic [31:0]      tb_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tx_t txq [2][$];
  ev_t glog[$], mlog[$], rlog[$];

  dmem_arbiter #(.MEM_BYTES(4096)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]), .m0_err_o(err[0]),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]), .m1_err_o(err[1]),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_en_o(mem_wr_en),
    .mem_rd_en_o(mem_rd_en), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] seed(int i);
    if (i == 1023) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Bench-side main_memory: combinational read, posedge write.
  assign mem_rdata = tb_mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 1024; i++) tb_mem[i] <= seed(i);
    else if (mem_wr_en) tb_mem[mem_addr[11:2]] <= mem_wdata;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: one transaction occupies the memory slot in the cycle after its grant,
  // and its response is visible the cycle after that.
  logic [31:0]      ref_mem [1024];
  int               last_p = 1;
  bit               pend_v = 0;
  int               pend_p = 0;
  bit               pend_we = 0;
  logic [31:0]      pend_addr = 0, pend_wdata = 0;
  logic [1:0]       e_rvalid = 0, e_err = 0;
  logic [1:0][31:0] e_rdata = 0;

  function automatic bit addr_ok(logic [31:0] a);
    return (a % 4) == 0 && a < 4096;
  endfunction

  function automatic int pick();
    if (reset || pend_v) return -1;
    if (req[0] && req[1]) return 1 - last_p;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int idx;
    bit ok;
    if (init_mem) for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    w = pick();
    e_rvalid = 0;
    e_err    = 0;
    if (reset) begin
      pend_v  = 0;
      last_p  = 1;
      e_rdata = 0;
    end else if (pend_v) begin
      ok  = addr_ok(pend_addr);
      idx = int'(pend_addr % 4096) / 4;
      e_rvalid[pend_p] = 1'b1;
      e_err[pend_p]    = !ok;
      e_rdata[pend_p]  = (ok && !pend_we) ? ref_mem[idx] : 32'h0;
      if (ok && pend_we) ref_mem[idx] = pend_wdata;
      last_p = pend_p;
      pend_v = 0;
    end else if (w >= 0) begin
      pend_v     = 1;
      pend_p     = w;
      pend_we    = we[w];
      pend_addr  = addr[w];
      pend_wdata = wdata[w];
    end
  endtask

  always begin
    int  w;
    bit  act;
    ev_t ev;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    w   = pick();
    act = pend_v && !reset;
    chk($sformatf("c%0d gnt", cyc), 32'(gnt), (w < 0) ? 32'h0 : (w == 0 ? 32'h1 : 32'h2));
    chk($sformatf("c%0d rvalid", cyc), 32'(rvalid), 32'(e_rvalid));
    chk($sformatf("c%0d err", cyc), 32'(err), 32'(e_err));
    chk($sformatf("c%0d rdata0", cyc), rdata[0], e_rdata[0]);
    chk($sformatf("c%0d rdata1", cyc), rdata[1], e_rdata[1]);
    chk($sformatf("c%0d wr_en", cyc), 32'(mem_wr_en), 32'(act && pend_we && addr_ok(pend_addr)));
    chk($sformatf("c%0d rd_en", cyc), 32'(mem_rd_en), 32'(act && !pend_we && addr_ok(pend_addr)));
    chk($sformatf("c%0d mem_addr", cyc), mem_addr, act ? (pend_addr % 4096) : 32'h0);
    chk($sformatf("c%0d mem_wdata", cyc), mem_wdata, act ? pend_wdata : 32'h0);
    ev = '{cyc: cyc, p: 0, we: mem_wr_en, rd: mem_rd_en, e: 1'b0, a: mem_addr, d: mem_wdata};
    if (gnt != 2'b00) begin ev.p = gnt[1] ? 1 : 0; glog.push_back(ev); end
    if (mem_wr_en || mem_rd_en) mlog.push_back(ev);
    if (rvalid != 2'b00) begin
      ev.p = rvalid[1] ? 1 : 0;
      ev.e = err[ev.p];
      ev.d = rdata[ev.p];
      rlog.push_back(ev);
    end
  end

  // Requesters: hold req and payload until gnt, then move to the next queued transaction.
  logic [1:0] drv_g;
  int         idle_cnt [2] = '{0, 0};
  always begin
    @(negedge clk);
    drv_g = gnt;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (req[p] && drv_g[p]) begin
        void'(txq[p].pop_front());
        req[p] = 1'b0;
      end
      if (!req[p] && txq[p].size() > 0) begin
        if (idle_cnt[p] < txq[p][0].gap) idle_cnt[p]++;
        else begin
          idle_cnt[p] = 0;
          req[p]   = 1'b1;
          we[p]    = txq[p][0].we;
          addr[p]  = txq[p][0].addr;
          wdata[p] = txq[p][0].wdata;
        end
      end
    end
  end

  task automatic push(int p, bit w, logic [31:0] a, logic [31:0] d, int gap);
    tx_t t;
    t.we = w; t.addr = a; t.wdata = d; t.gap = gap;
    txq[p].push_back(t);
  endtask

  task automatic clear_logs();
    glog.delete(); mlog.delete(); rlog.delete();
  endtask

  task automatic wait_idle(string tag);
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 3; i++) begin
      @(negedge clk);
      if (txq[0].size() == 0 && txq[1].size() == 0 && req == 2'b00 && !pend_v && rvalid == 2'b00)
        quiet++;
      else
        quiet = 0;
    end
    chk({tag, " reached idle"}, 32'(quiet >= 3), 32'h1);
  endtask

  initial begin
    int wr_cnt;
    int bad;
    reset = 1'b1; init_mem = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0;
    push(0, 0, 32'h0, 32'h0, 0);
    push(1, 0, 32'h4, 32'h0, 0);
    @(posedge clk); #1 init_mem = 1'b0;
    @(negedge clk);
    chk("reset gnt a", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset gnt b", 32'(gnt), 32'h0);
    chk("reset req held", 32'(req), 32'h3);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("gnt after reset", 32'(gnt), 32'h1);
    wait_idle("reset");

    clear_logs();
    push(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    push(0, 0, 32'h0000_0010, 32'h0, 0);
    wait_idle("store-load");
    chk("sl resp count", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2 && glog.size() == 2 && mlog.size() == 2) begin
      chk("sl grant port", 32'(glog[0].p), 32'd0);
      chk("sl wr cycle", 32'(mlog[0].cyc - glog[0].cyc), 32'd1);
      chk("sl wr_en", 32'(mlog[0].we), 32'h1);
      chk("sl mem_addr", mlog[0].a, 32'h10);
      chk("sl rvalid cycle", 32'(rlog[0].cyc - glog[0].cyc), 32'd2);
      chk("sl store err", 32'(rlog[0].e), 32'h0);
      chk("sl load rdata", rlog[1].d, 32'hDEAD_BEEF);
    end

    push(1, 0, 32'h0, 32'h0, 0);
    wait_idle("pre-contention");
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 32'h100 + 32'(4 * i), 32'h0, 0);
      push(1, 0, 32'h200 + 32'(4 * i), 32'h0, 0);
    end
    wait_idle("contention");
    chk("ct grant count", 32'(glog.size()), 32'd8);
    chk("ct resp count", 32'(rlog.size()), 32'd8);
    if (glog.size() == 8 && rlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("ct grant %0d port", i), 32'(glog[i].p), 32'(i % 2));
        if (i > 0) begin
          chk($sformatf("ct grant %0d spacing", i), 32'(glog[i].cyc - glog[i-1].cyc), 32'd2);
          chk($sformatf("ct resp %0d distinct cycle", i), 32'(rlog[i].cyc != rlog[i-1].cyc), 32'h1);
        end
      end
    end

    clear_logs();
    push(1, 1, 32'h0000_0006, 32'hBAD0_0001, 0);
    push(1, 1, 32'h0000_1000, 32'hBAD0_0002, 0);
    push(1, 0, 32'h0000_0004, 32'h0, 0);
    wait_idle("errors");
    wr_cnt = 0;
    foreach (mlog[i]) if (mlog[i].we) wr_cnt++;
    chk("err no writes", 32'(wr_cnt), 32'd0);
    chk("err resp count", 32'(rlog.size()), 32'd3);
    if (rlog.size() == 3) begin
      chk("err misaligned port", 32'(rlog[0].p), 32'd1);
      chk("err misaligned flag", 32'(rlog[0].e), 32'h1);
      chk("err range flag", 32'(rlog[1].e), 32'h1);
      chk("err reload data", rlog[2].d, seed(1));
    end
    chk("err mem word 0", tb_mem[0], seed(0));

    clear_logs();
    push(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (gnt[0]) seen = 1;
      end
      chk("rst-mid grant seen", 32'(seen), 32'h1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst-mid wr_en", 32'(mem_wr_en), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_idle("reset-mid");
    chk("rst-mid no response", 32'(rlog.size()), 32'd0);
    chk("rst-mid mem unchanged", tb_mem[8], seed(8));

    clear_logs();
    push(0, 0, 32'h0000_0FFC, 32'h0, 0);
    wait_idle("truncation");
    chk("tr mem log", 32'(mlog.size()), 32'd1);
    chk("tr resp log", 32'(rlog.size()), 32'd1);
    if (mlog.size() == 1 && rlog.size() == 1) begin
      chk("tr mem_addr", mlog[0].a, 32'h0000_0FFC);
      chk("tr rdata", rlog[0].d, 32'h1234_5678);
    end

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 150; i++) begin
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, 1023)) * 4;
        else if (r == 7) a = (32'($urandom_range(0, 1023)) * 4) | 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
        else             a = $urandom;
        push(p, bit'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end
    end
    for (int i = 0; i < 6000 && (txq[0].size() > 0 || txq[1].size() > 0); i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 79) == 0);
    end
    reset = 1'b0;
    wait_idle("random");

    bad = 0;
    for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    chk("final memory image mismatching words", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory (`main_memory`, 1024 x 32-bit, combinational read, posedge write). It shares the single memory port between the core load/store unit (port 0) and the debug/loader port (port 1) using round-robin arbitration. Each access is latched, issued for exactly one cycle with the correct `rd_en`/`wr_en`, and completed with a registered response pulse. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
- `MEM_BYTES`, 4096: addressable bytes; addresses `>= MEM_BYTES` are errors.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  reset; synchronous and active-high.
- `m0_req`  in  1  port 0 request; held with its payload until `m0_gnt`.
- `m0_we`  in  1  1 = store, 0 = load.
- `m0_addr`  in  32  byte address.
- `m0_wdata`  in  32  store data.
- `m0_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`  out  1  one-cycle response pulse, for loads and stores.
- `m0_rdata`  out  32  load data; valid with `m0_rvalid`.
- `m0_err`  out  1  access rejected; valid with `m0_rvalid`.
- `m1_*`: identical set for port 1.
- `mem_addr`  out  32  address to memory: `{20'b0, addr[11:0]}`.
- `mem_wdata`  out  32  store data to memory.
- `mem_wr_en`  out  1  memory write enable.
- `mem_rd_en`  out  1  memory read enable.
- `mem_rdata`  in  32  memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE**
  - If any `req` is high, select a winner and assert its `gnt` combinationally.
  - On the posedge, latch the winner id and its `we`, `addr`, `wdata`. Compute `err = (addr[1:0] != 0) || (addr >= MEM_BYTES)`. Go to ACCESS.
  - If no request, stay in IDLE.
- **ACCESS**
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - `mem_rd_en = !we && !err && !reset`.
  - `mem_wr_en = we && !err && !reset`.
  - On the posedge:
    - Capture `rdata`: `mem_rdata` for a good load; 0 for stores and errors.
    - Set the winner's `rvalid = 1` and `err` = the latched error.
    - Update `last = winner`.
    - Return to IDLE.
- **Round-robin**
  - Only one request: it wins.
  - Both requests: the port `!= last` wins.
  - Reset value of `last` is 1, so port 0 wins the first contention.
- No `gnt` is asserted in ACCESS. Requesters keep `req` high and wait.
- Outside ACCESS: `mem_rd_en = mem_wr_en = 0`, and `mem_addr`/`mem_wdata` = 0.

## Timing
- Reset values: state IDLE, `last` 1, all `gnt`/`rvalid`/`err` 0, all `rdata` 0, all `mem_*` outputs 0.
- Latency: `gnt` in cycle T, memory access in T+1, `rvalid` in T+2.
- `rvalid`, `rdata` and `err` are registered. They are held one cycle, then `rvalid`/`err` return to 0. `rdata` holds its value until the next response on that port.
- Throughput: one access per 2 cycles. Back-to-back: a new `gnt` can appear in the same cycle as the previous `rvalid`.
- Reset asserted during ACCESS:
  - `mem_wr_en` is gated low that cycle, so no store occurs.
  - The next state is IDLE, and no `rvalid` is produced.
- A store to a misaligned or out-of-range address never asserts `mem_wr_en`. The requester still receives `rvalid` with `err` = 1.
- Only one port's `rvalid` can be high in any cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles with both `req` = 1. Require all outputs 0 and no `gnt` during reset; `m0_gnt` rises in the first cycle after reset.
- **Store then load on port 0:**
  - Store 0x0000_0010 with data 0xDEAD_BEEF. Require `mem_wr_en` = 1 with `mem_addr` = 0x10 in T+1, and `m0_rvalid` = 1, `m0_err` = 0 in T+2.
  - Then load 0x10. Require `m0_rdata` = 0xDEAD_BEEF.
- **Contention:** both ports hold loads continuously. Require grant order 0,1,0,1 with each `gnt` 2 cycles apart, and `m1_rvalid` never coincident with `m0_rvalid`.
- **Errors:**
  - Port 1 store to 0x0000_0006 and to 0x0000_1000. Require `mem_wr_en` to stay 0 and `m1_err` = 1 with `m1_rvalid` for each.
  - A subsequent load of 0x4 must return the unchanged data.
- **Reset mid-access:** issue a store to 0x20, then assert `reset` in its ACCESS cycle. Require `mem_wr_en` = 0 in that cycle, no `rvalid`, and the prior contents of 0x20 unchanged.
- **Address truncation:** a load from 0x0000_0FFC with the memory location preloaded to 0x1234_5678. Require `mem_addr` = 0xFFC and `m0_rdata` = 0x1234_5678.
